dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Handshaked data-memory responder: the target end of the CPU's load/store port.
- Replaces the zero-latency dmem with a valid/ready request channel, a programmable wait-state counter and a held response channel.
- Lets the multicycle/pipelined cores be exercised against a memory that stalls.
- Sits between the core's load/store unit and a word-organised on-chip RAM mapped at the data segment.

Parameters:
- BASE_ADDR, 32'h10010000, byte address of word 0 (data segment base).
- DEPTH_WORDS, 256, number of 32-bit words; power of two, 4..4096.
- LATENCY, 2, wait cycles between request accept and response; legal 0..15.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  initiator presents a request.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_wstrb  in  4  byte-lane enables; present only with DMEM_WSTRB_EN.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  initiator accepts the response.
- rsp_rdata  out  32  load data; 0 for a successful store.
- rsp_err  out  1  request was misaligned or out of range.

Behaviour:
- Reset (synchronous):
  - state = IDLE; req_ready = 1; rsp_valid = 0; rsp_err = 0; rsp_rdata = 0; wait counter = 0.
  - All memory words are cleared to 0.
- States:
  - IDLE: req_ready = 1. If req_valid = 1, capture we, addr, wdata (and wstrb) at the edge. Go to WAIT when LATENCY > 0, else go to ACCESS.
  - WAIT: req_ready = 0. Counter loads LATENCY-1 on entry and decrements each cycle. Go to ACCESS when counter = 0.
  - ACCESS: one cycle, req_ready = 0.
    - Decode the captured address: index = (addr - BASE_ADDR) >> 2.
    - Error when addr[1:0] != 0, or addr < BASE_ADDR, or addr >= BASE_ADDR + 4*DEPTH_WORDS.
    - On error: no write, rdata = 32'hDEADBEEF, err = 1.
    - On load: rdata = mem[index].
    - On store: mem[index] is written at this edge, rdata = 0.
    - Go to RESP.
  - RESP: rsp_valid = 1; rsp_rdata and rsp_err are held stable. Go to IDLE on rsp_ready = 1. rsp_valid deasserts the following cycle.
- Latency: accept edge to first rsp_valid cycle is LATENCY+2 cycles. One outstanding request; no pipelining.
- Initiator rules:
  - Request fields may change freely once accepted; the responder uses only captured copies.
  - req_valid may drop without acceptance only while req_ready = 0; the responder ignores it.
- Load after store to the same address returns the stored value (store committed in ACCESS before the next accept).
- rsp_ready asserted before rsp_valid has no effect.
- Reset mid-operation: state aborts to IDLE. A store not yet in ACCESS is never committed; any response in flight is discarded.
- Address arithmetic is 32-bit unsigned with no wrap: BASE_ADDR-4 and BASE_ADDR+4*DEPTH_WORDS are both errors.

Optional Feature:
- Macro: DMEM_WSTRB_EN.
- Defined:
  - req_wstrb port exists and is captured with the request.
  - A store writes only lanes with wstrb[i] = 1 (lane i = bits 8i+7:8i).
  - wstrb = 4'b0000 on a store gives err = 1 and no write.
  - Loads ignore wstrb.
- Undefined: port absent; every store writes all 4 bytes.

Test Plan:
- Reset, then load from 32'h10010000 → rsp_valid exactly 4 cycles after accept (LATENCY=2), rdata 32'h00000000, err 0; req_ready low from accept until the cycle after rsp handshake.
- Store 32'hCAFEF00D to 32'h10010010, then load from 32'h10010010 → load returns 32'hCAFEF00D, err 0. Load from 32'h10010014 → returns 0.
- Load from 32'h10010002, and store to 32'h10010400 (DEPTH_WORDS=256) → both err 1, rdata 32'hDEADBEEF; a later load of word 0 is unchanged.
- Backpressure: hold rsp_ready = 0 for 5 cycles after rsp_valid → rsp_valid/rdata/err stay stable and req_ready stays 0. On rsp_ready = 1 → handshake completes and IDLE follows next cycle.
- Assert rst in WAIT of a store of 32'h12345678 to 32'h10010020 → rsp_valid never rises; a subsequent load of 32'h10010020 returns 0.
- With DMEM_WSTRB_EN: store 32'hFFFFFFFF, then store 32'h000000AA with wstrb 4'b0001 to the same word → load returns 32'hFFFFFFAA. Store with wstrb 4'b0000 → err 1, word unchanged.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready data-memory target with a programmable wait-state delay
// and a held response. Byte-lane strobes are enabled by defining DMEM_WSTRB_EN.
module dmem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h10010000,
    parameter int          DEPTH_WORDS = 256,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
`ifdef DMEM_WSTRB_EN
    input  logic [3:0]  i_req_wstrb,
`endif
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err
);

    // state  | meaning
    // IDLE   | ready for a request; captures fields on accept
    // WAIT   | burning LATENCY wait cycles
    // ACCESS | decode, commit store or read word
    // RESP   | response held until the initiator takes it
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN     = 33'(4 * DEPTH_WORDS);
    localparam logic [3:0]  LAT_M1   = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam bit          HAS_WAIT = (LATENCY > 0);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic [32:0]      w_off;
    logic [IDX_W-1:0] w_idx;
    logic [3:0]       w_be;
    logic             w_strb_err;
    logic             w_err;
    logic             w_accept;

    assign w_accept = (r_state == S_IDLE) && i_req_valid;

    // 33-bit offset: addresses below the base come out with the top bit set and so
    // compare above SPAN, which folds both range checks into one compare.
    assign w_off = {1'b0, r_addr} - {1'b0, BASE_ADDR};
    assign w_idx = w_off[IDX_W+1:2];
    assign w_err = (r_addr[1:0] != 2'b00) || (w_off >= SPAN) || w_strb_err;

`ifdef DMEM_WSTRB_EN
    logic [3:0] r_wstrb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstrb <= 4'b0000;
        end else if (w_accept) begin
            r_wstrb <= i_req_wstrb;
        end
    end

    assign w_be       = r_wstrb;
    assign w_strb_err = r_we && (r_wstrb == 4'b0000);
`else
    assign w_be       = 4'b1111;
    assign w_strb_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_req_valid) begin
                    w_state_nxt = HAS_WAIT ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: w_state_nxt = S_RESP;
            S_RESP: begin
                if (i_rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_we    <= i_req_we;
                        r_addr  <= i_req_addr;
                        r_wdata <= i_req_wdata;
                        r_cnt   <= LAT_M1;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_ACCESS: begin
                    r_err <= w_err;
                    if (w_err) begin
                        r_rdata <= 32'hDEADBEEF;
                    end else if (r_we) begin
                        r_rdata <= 32'd0;
                        for (int b = 0; b < 4; b++) begin
                            if (w_be[b]) begin
                                r_mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                            end
                        end
                    end else begin
                        r_rdata <= r_mem[w_idx];
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_req_ready = (r_state == S_IDLE);
    assign o_rsp_valid = (r_state == S_RESP);
    assign o_rsp_rdata = r_rdata;
    assign o_rsp_err   = r_err;

endmodule
